memory_stage: RTL and testbench
===============================

MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 SHALL provide parameter SRAM_ADDR_W, default 32, width of data_addr.
REQ-002 SHALL have ports, one clock; reset asynchronous, active-low:
clk  in  1  sole clock, rising edge
resetn  in  1  async active-low reset
exe_valid  in  1  execute-stage instruction valid
mem_allowin  out  1  this stage accepts an instruction this cycle
exe_mem_read / exe_reg_en  in  1/1  load flag / register-write flag
exe_mem_wen  in  4  store byte enables; nonzero = store
alu_result / exe_mem_wdata / exe_load_rt_data  in  32 each  byte address / store data / old rt for LWL,LWR
exe_reg_waddr / exe_load_type  in  5/3  dest reg / LW=0 LB=1 LBU=2 LH=3 LHU=4 LWL=5 LWR=6
data_req / data_wr  out  1/1  SRAM request / write flag
data_wen / data_addr / data_wdata  out  4/SRAM_ADDR_W/32  byte enables / word-aligned address / write data
data_addr_ok / data_data_ok  in  1/1  request accepted / read data or write ack
data_rdata  in  32  read data
wb_allowin  in  1  writeback accepts
mem_valid / mem_reg_en / mem_reg_waddr / mem_reg_wdata  out  1/1/5/32  result to writeback
exe_MD_complete / exe_MD_result  in  1/64  mult/div done / {hi,lo} (MEMORY_HILO_EN only)
hi / lo  out  32/32  HI/LO registers (MEMORY_HILO_EN only)

Function
REQ-003 FSM states IDLE, REQ, WAIT, DONE, registered.
REQ-004 mem_allowin = (IDLE) | (DONE & wb_allowin); accept = exe_valid & mem_allowin.
REQ-005 On accept, capture all exe_* inputs into stage registers; memory op (exe_mem_read | exe_mem_wen!=0) -> REQ, else -> DONE (latency 1).
REQ-006 In REQ: data_req=1, data_wr=(wen!=0), data_addr={addr[31:2],2'b00}, data_wen/data_wdata from captured regs, all stable until data_addr_ok; data_addr_ok -> WAIT.
REQ-007 data_data_ok SHALL be ignored outside WAIT; in WAIT, data_data_ok -> DONE, loads capture data_rdata (min memory latency 3 cycles).
REQ-008 In DONE: mem_valid=1; wb_allowin & !exe_valid -> IDLE; wb_allowin & exe_valid -> accept back-to-back per REQ-005.
REQ-009 mem_reg_wdata: non-load = captured alu_result; LW = rdata; LB/LBU = byte addr[1:0] sign/zero-extended; LH/LHU = half addr[1] sign/zero-extended.
REQ-010 LWL by addr[1:0]: 0 {rd[7:0],rt[23:0]}; 1 {rd[15:0],rt[15:0]}; 2 {rd[23:0],rt[7:0]}; 3 rd.
REQ-011 LWR by addr[1:0]: 0 rd; 1 {rt[31:24],rd[31:8]}; 2 {rt[31:16],rd[31:16]}; 3 {rt[31:8],rd[31:24]}.
REQ-012 Stores SHALL force mem_reg_en=0 in output.
REQ-013 mem_valid=0 in IDLE/REQ/WAIT; mem_reg_* hold last value, undefined-safe (consumers gate on mem_valid).

Reset
REQ-014 resetn low SHALL asynchronously force state=IDLE, data_req=0, mem_valid=0, all stage registers and mem_reg_*=0, hi=lo=0.
REQ-015 Reset mid-transaction SHALL abandon it; a data_data_ok arriving in IDLE after reset SHALL be ignored.

Configuration
REQ-016 MEMORY_HILO_EN defined: hi/lo ports and registers exist; exe_MD_complete loads {hi,lo}<=exe_MD_result same edge, independent of FSM/stall.
REQ-017 MEMORY_HILO_EN undefined: exe_MD_complete, exe_MD_result, hi, lo ports absent; no HI/LO storage.

Structure
REQ-018 Shared package: load-type constants (LW..LWR), FSM state encoding, ExcCode-independent width constants.
REQ-019 One sub-module load_align (combinational REQ-009..011: addr[1:0], type, rdata, rt -> wdata).

Verification
REQ-020 ALU op, reg 5, result 0x1234_5678, wb_allowin=1 -> mem_valid next cycle, wdata 0x1234_5678, no data_req.
REQ-021 LB addr 0x103, rdata 0x80AA_BBCC, addr_ok after 2 cycles, data_ok 1 later -> wdata 0xFFFF_FF80; data_addr 0x100 stable while waiting.
REQ-022 LWL addr 0x101, rt 0x1122_3344, rdata 0xAABB_CCDD -> 0xCCDD_3344; LWR addr 0x102 same data -> 0x1122_AABB.
REQ-023 SW wen 0xF addr 0x200, data 0xDEAD_BEEF -> data_wr=1, data_wen 0xF; on data_ok mem_valid=1, mem_reg_en=0.
REQ-024 DONE with wb_allowin=0 for 3 cycles -> outputs held, mem_allowin=0; then wb_allowin=1 with exe_valid=1 -> new instruction accepted same edge.
REQ-025 resetn low during WAIT -> IDLE, mem_valid=0; later data_data_ok -> no output; with MEMORY_HILO_EN, MD result 0x1_0000_0002 -> hi=1, lo=2.

Source files
------------

// File: rtl/memory_stage_pkg.sv
// Shared constants for the memory stage: load-type codes, FSM state encoding
// and datapath widths.
package memory_stage_pkg;

  localparam int DATA_W      = 32;
  localparam int REG_ADDR_W  = 5;
  localparam int WEN_W       = 4;
  localparam int LOAD_TYPE_W = 3;

  localparam logic [LOAD_TYPE_W-1:0] LT_LW  = 3'd0;
  localparam logic [LOAD_TYPE_W-1:0] LT_LB  = 3'd1;
  localparam logic [LOAD_TYPE_W-1:0] LT_LBU = 3'd2;
  localparam logic [LOAD_TYPE_W-1:0] LT_LH  = 3'd3;
  localparam logic [LOAD_TYPE_W-1:0] LT_LHU = 3'd4;
  localparam logic [LOAD_TYPE_W-1:0] LT_LWL = 3'd5;
  localparam logic [LOAD_TYPE_W-1:0] LT_LWR = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/memory_stage_load_align.sv
// Load alignment: selects/extends the addressed byte or half and merges the
// unaligned LWL/LWR word with the old rt value.
module load_align
  import memory_stage_pkg::*;
(
  input  logic [1:0]             addr_lo,
  input  logic [LOAD_TYPE_W-1:0] load_type,
  input  logic [DATA_W-1:0]      rdata,
  input  logic [DATA_W-1:0]      rt,
  output logic [DATA_W-1:0]      wdata
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    wdata = rdata;
    case (load_type)
      LT_LW:  wdata = rdata;
      LT_LB:  wdata = {{24{byte_sel[7]}}, byte_sel};
      LT_LBU: wdata = {24'd0, byte_sel};
      LT_LH:  wdata = {{16{half_sel[15]}}, half_sel};
      LT_LHU: wdata = {16'd0, half_sel};
      LT_LWL: begin
        case (addr_lo)
          2'd0: wdata = {rdata[7:0],  rt[23:0]};
          2'd1: wdata = {rdata[15:0], rt[15:0]};
          2'd2: wdata = {rdata[23:0], rt[7:0]};
          default: wdata = rdata;
        endcase
      end
      LT_LWR: begin
        case (addr_lo)
          2'd1: wdata = {rt[31:24], rdata[31:8]};
          2'd2: wdata = {rt[31:16], rdata[31:16]};
          2'd3: wdata = {rt[31:8],  rdata[31:24]};
          default: wdata = rdata;
        endcase
      end
      default: wdata = rdata;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// Pipeline memory stage: one instruction in flight, SRAM request/response
// handshake, load alignment. Optional HI/LO registers under MEMORY_HILO_EN.
//
// state | meaning
// IDLE  | empty, accepting a new instruction
// REQ   | SRAM request held until data_addr_ok
// WAIT  | waiting for data_data_ok (read data / write ack)
// DONE  | result valid to writeback, can accept back-to-back
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int SRAM_ADDR_W = 32
)
(
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   exe_valid,
  output logic                   mem_allowin,
  input  logic                   exe_mem_read,
  input  logic                   exe_reg_en,
  input  logic [WEN_W-1:0]       exe_mem_wen,
  input  logic [DATA_W-1:0]      alu_result,
  input  logic [DATA_W-1:0]      exe_mem_wdata,
  input  logic [DATA_W-1:0]      exe_load_rt_data,
  input  logic [REG_ADDR_W-1:0]  exe_reg_waddr,
  input  logic [LOAD_TYPE_W-1:0] exe_load_type,
  output logic                   data_req,
  output logic                   data_wr,
  output logic [WEN_W-1:0]       data_wen,
  output logic [SRAM_ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0]      data_wdata,
  input  logic                   data_addr_ok,
  input  logic                   data_data_ok,
  input  logic [DATA_W-1:0]      data_rdata,
  input  logic                   wb_allowin,
  output logic                   mem_valid,
  output logic                   mem_reg_en,
  output logic [REG_ADDR_W-1:0]  mem_reg_waddr,
  output logic [DATA_W-1:0]      mem_reg_wdata
`ifdef MEMORY_HILO_EN
  ,
  input  logic                   exe_MD_complete,
  input  logic [2*DATA_W-1:0]    exe_MD_result,
  output logic [DATA_W-1:0]      hi,
  output logic [DATA_W-1:0]      lo
`endif
);

  state_t state, state_nxt;

  logic                   accept;
  logic                   mem_op_in;
  logic                   r_mem_read;
  logic                   r_reg_en;
  logic [WEN_W-1:0]       r_wen;
  logic [DATA_W-1:0]      r_addr;
  logic [DATA_W-1:0]      r_wdata;
  logic [DATA_W-1:0]      r_rt;
  logic [REG_ADDR_W-1:0]  r_waddr;
  logic [LOAD_TYPE_W-1:0] r_load_type;
  logic [DATA_W-1:0]      r_rdata;
  logic [DATA_W-1:0]      load_wdata;
  logic [DATA_W-1:0]      addr_word;

  assign mem_allowin = (state == ST_IDLE) | ((state == ST_DONE) & wb_allowin);
  assign accept      = exe_valid & mem_allowin;
  assign mem_op_in   = exe_mem_read | (|exe_mem_wen);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = mem_op_in ? ST_REQ : ST_DONE;
      ST_REQ:  if (data_addr_ok) state_nxt = ST_WAIT;
      ST_WAIT: if (data_data_ok) state_nxt = ST_DONE;
      ST_DONE: begin
        if (accept)          state_nxt = mem_op_in ? ST_REQ : ST_DONE;
        else if (wb_allowin) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_mem_read  <= 1'b0;
      r_reg_en    <= 1'b0;
      r_wen       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rt        <= '0;
      r_waddr     <= '0;
      r_load_type <= '0;
    end else if (accept) begin
      r_mem_read  <= exe_mem_read;
      r_reg_en    <= exe_reg_en;
      r_wen       <= exe_mem_wen;
      r_addr      <= alu_result;
      r_wdata     <= exe_mem_wdata;
      r_rt        <= exe_load_rt_data;
      r_waddr     <= exe_reg_waddr;
      r_load_type <= exe_load_type;
    end
  end

  // data_data_ok is only meaningful while a response is outstanding
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      r_rdata <= '0;
    else if ((state == ST_WAIT) && data_data_ok && r_mem_read)
      r_rdata <= data_rdata;
  end

  assign addr_word  = {r_addr[DATA_W-1:2], 2'b00};
  assign data_req   = (state == ST_REQ);
  assign data_wr    = |r_wen;
  assign data_wen   = r_wen;
  assign data_addr  = SRAM_ADDR_W'(addr_word);
  assign data_wdata = r_wdata;

  load_align u_load_align (
    .addr_lo   (r_addr[1:0]),
    .load_type (r_load_type),
    .rdata     (r_rdata),
    .rt        (r_rt),
    .wdata     (load_wdata)
  );

  assign mem_valid     = (state == ST_DONE);
  assign mem_reg_en    = r_reg_en & ~(|r_wen);
  assign mem_reg_waddr = r_waddr;
  assign mem_reg_wdata = r_mem_read ? load_wdata : r_addr;

`ifdef MEMORY_HILO_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi <= '0;
      lo <= '0;
    end else if (exe_MD_complete) begin
      {hi, lo} <= exe_MD_result;
    end
  end
`endif

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboarded random bench for memory_stage with an SRAM responder model and
// a writeback monitor; HI/LO checks included when MEMORY_HILO_EN is defined.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        exe_valid, mem_allowin, exe_mem_read, exe_reg_en;
  logic [3:0]  exe_mem_wen;
  logic [31:0] alu_result, exe_mem_wdata, exe_load_rt_data;
  logic [4:0]  exe_reg_waddr;
  logic [2:0]  exe_load_type;
  logic        data_req, data_wr;
  logic [3:0]  data_wen;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        wb_allowin;
  logic        mem_valid, mem_reg_en;
  logic [4:0]  mem_reg_waddr;
  logic [31:0] mem_reg_wdata;
`ifdef MEMORY_HILO_EN
  logic        exe_MD_complete;
  logic [63:0] exe_MD_result;
  logic [31:0] hi, lo;
`endif

  memory_stage #(.SRAM_ADDR_W(32)) dut (
    .clk(clk), .resetn(resetn), .exe_valid(exe_valid), .mem_allowin(mem_allowin),
    .exe_mem_read(exe_mem_read), .exe_reg_en(exe_reg_en), .exe_mem_wen(exe_mem_wen),
    .alu_result(alu_result), .exe_mem_wdata(exe_mem_wdata), .exe_load_rt_data(exe_load_rt_data),
    .exe_reg_waddr(exe_reg_waddr), .exe_load_type(exe_load_type),
    .data_req(data_req), .data_wr(data_wr), .data_wen(data_wen), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata), .wb_allowin(wb_allowin), .mem_valid(mem_valid),
    .mem_reg_en(mem_reg_en), .mem_reg_waddr(mem_reg_waddr), .mem_reg_wdata(mem_reg_wdata)
`ifdef MEMORY_HILO_EN
    , .exe_MD_complete(exe_MD_complete), .exe_MD_result(exe_MD_result), .hi(hi), .lo(lo)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  wen;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic        reg_en;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    bit          alu;
    int          acc_cyc;
  } out_t;

  req_t        req_q[$];
  out_t        exp_q[$];
  logic [31:0] mem [int];

  int total = 0;
  int bad = 0;
  int addr_dly = -1;
  int data_lat = -1;
  int stall_req = 0;
  bit auto_mem = 1;
  bit wb_rand = 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_rd(input int w);
    if (!mem.exists(w)) mem[w] = $urandom;
    return mem[w];
  endfunction

  // Reference load result from the architectural definition of each load type
  function automatic logic [31:0] ref_load(input logic [2:0] t, input logic [1:0] a,
                                           input logic [31:0] rd, input logic [31:0] rt);
    logic [7:0]  b;
    logic [15:0] h;
    int          keep;
    logic [63:0] m;
    b = rd[8*a +: 8];
    h = a[1] ? rd[31:16] : rd[15:0];
    case (t)
      3'd1: return {{24{b[7]}}, b};
      3'd2: return {24'd0, b};
      3'd3: return {{16{h[15]}}, h};
      3'd4: return {16'd0, h};
      3'd5: begin
        keep = 3 - int'(a);
        m = (64'd1 << (8 * keep)) - 64'd1;
        return 32'((64'(rd) << (8 * keep)) | (64'(rt) & m));
      end
      3'd6: return (rd >> (8 * int'(a))) | (rt & ~(32'hFFFF_FFFF >> (8 * int'(a))));
      default: return rd;
    endcase
  endfunction

  task automatic issue(input logic rd, input logic ren, input logic [3:0] wen,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rt,
                       input logic [4:0] wa, input logic [2:0] lt,
                       input bit use_exp, input logic [31:0] exp_w);
    bit          got;
    out_t        o;
    req_t        r;
    logic [31:0] word;
    int          idx;
    @(negedge clk);
    exe_valid = 1'b1; exe_mem_read = rd; exe_reg_en = ren; exe_mem_wen = wen;
    alu_result = addr; exe_mem_wdata = wd; exe_load_rt_data = rt;
    exe_reg_waddr = wa; exe_load_type = lt;
    got = 0;
    for (int n = 0; n < 500 && !got; n++) begin
      #4;
      if (mem_allowin) got = 1;
      else @(negedge clk);
    end
    if (!got) begin
      chk("accept_timeout", 64'd0, 64'd1);
      exe_valid = 1'b0;
      return;
    end
    idx = int'(addr[31:2]);
    o.acc_cyc = cyc + 1;
    o.alu     = !(rd || wen != 4'd0);
    o.reg_en  = ren && (wen == 4'd0);
    o.waddr   = wa;
    if (rd) o.wdata = ref_load(lt, addr[1:0], mem_rd(idx), rt);
    else    o.wdata = addr;
    if (use_exp) o.wdata = exp_w;
    if (!o.alu) begin
      r = '{wr: (wen != 4'd0), addr: {addr[31:2], 2'b00}, wen: wen, wdata: wd};
      req_q.push_back(r);
    end
    if (wen != 4'd0) begin
      word = mem_rd(idx);
      for (int b = 0; b < 4; b++) if (wen[b]) word[8*b +: 8] = wd[8*b +: 8];
      mem[idx] = word;
    end
    exp_q.push_back(o);
    @(posedge clk);
    #1 exe_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 400 && (exp_q.size() != 0 || req_q.size() != 0); n++) @(negedge clk);
    if (exp_q.size() != 0 || req_q.size() != 0)
      chk("drain_timeout", 64'(exp_q.size() + req_q.size()), 64'd0);
    exp_q.delete();
    req_q.delete();
    repeat (4) @(negedge clk);
  endtask

  // SRAM responder
  initial begin
    req_t        r;
    int          d, lat;
    bit          have;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
    forever begin
      @(negedge clk);
      if (!auto_mem) continue;
      data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = $urandom;
      if (data_req) begin
        have = (req_q.size() != 0);
        if (!have) begin
          chk("unexpected_req", 64'd1, 64'd0);
          r = '{wr: data_wr, addr: data_addr, wen: data_wen, wdata: data_wdata};
        end else begin
          r = req_q.pop_front();
          chk("req_fields", {data_wr, data_addr, data_wen, data_wdata}, r);
        end
        d   = (addr_dly < 0) ? $urandom_range(0, 2) : addr_dly;
        lat = (data_lat < 0) ? $urandom_range(1, 3) : data_lat;
        repeat (d) begin
          @(negedge clk);
          data_rdata = $urandom;
          chk("req_stable", {data_req, data_wr, data_addr, data_wen, data_wdata}, {1'b1, r});
        end
        data_addr_ok = 1'b1;
        @(negedge clk);
        data_addr_ok = 1'b0;
        repeat (lat - 1) @(negedge clk);
        data_data_ok = 1'b1;
        data_rdata = r.wr ? $urandom : mem_rd(int'(r.addr[31:2]));
      end else if ($urandom_range(0, 9) == 0) begin
        data_data_ok = 1'b1;
      end
    end
  end

  // Writeback monitor
  initial begin
    bit   pv, pc, wb;
    int   stall_left;
    out_t cur;
    pv = 0; pc = 0; stall_left = 0;
    cur = '{reg_en: 1'b0, waddr: 5'd0, wdata: 32'd0, alu: 1'b0, acc_cyc: 0};
    wb_allowin = 1'b1;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        pv = 0; pc = 0; wb_allowin = 1'b1;
        continue;
      end
      if (mem_valid) begin
        if (!pv || pc) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output", 64'd1, 64'd0);
            cur = '{reg_en: mem_reg_en, waddr: mem_reg_waddr, wdata: mem_reg_wdata, alu: 1'b0, acc_cyc: 0};
          end else begin
            cur = exp_q.pop_front();
            chk("reg_en", mem_reg_en, cur.reg_en);
            chk("reg_waddr", mem_reg_waddr, cur.waddr);
            chk("reg_wdata", mem_reg_wdata, cur.wdata);
            if (cur.alu) chk("alu_latency", 64'(cyc), 64'(cur.acc_cyc));
            if (stall_req > 0) begin
              stall_left = stall_req;
              stall_req = 0;
            end
          end
        end else begin
          chk("hold_outputs", {mem_reg_en, mem_reg_waddr, mem_reg_wdata},
              {cur.reg_en, cur.waddr, cur.wdata});
        end
        if (stall_left > 0) begin
          wb = 0;
          stall_left--;
        end else begin
          wb = wb_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
      end else begin
        wb = wb_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      wb_allowin = wb;
      #1;
      if (mem_valid) chk("mem_allowin_done", mem_allowin, wb);
      pc = mem_valid && wb;
      pv = mem_valid;
    end
  end

  initial begin
    int          k;
    logic [2:0]  lt;
    logic [31:0] a;
    logic [3:0]  wens [7];
    wens = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
    exe_valid = 0; exe_mem_read = 0; exe_reg_en = 0; exe_mem_wen = 0;
    alu_result = 0; exe_mem_wdata = 0; exe_load_rt_data = 0;
    exe_reg_waddr = 0; exe_load_type = 0;
`ifdef MEMORY_HILO_EN
    exe_MD_complete = 0; exe_MD_result = 0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_mem_valid", mem_valid, 1'b0);
    chk("rst_data_req", data_req, 1'b0);
    chk("rst_allowin", mem_allowin, 1'b1);
    chk("rst_reg_en", mem_reg_en, 1'b0);
    chk("rst_reg_waddr", mem_reg_waddr, 5'd0);
    chk("rst_reg_wdata", mem_reg_wdata, 32'd0);
`ifdef MEMORY_HILO_EN
    chk("rst_hilo", {hi, lo}, 64'd0);
`endif
    resetn = 1'b1;

    // directed cases
    wb_rand = 0; addr_dly = 2; data_lat = 1;
    mem[32'h40] = 32'hAABB_CCDD;
    issue(0, 1, 4'h0, 32'h1234_5678, 32'h0, 32'h0, 5'd5, 3'd0, 1, 32'h1234_5678);
    issue(1, 1, 4'h0, 32'h0000_0101, 32'h0, 32'h1122_3344, 5'd8, 3'd5, 1, 32'hCCDD_3344);
    issue(1, 1, 4'h0, 32'h0000_0102, 32'h0, 32'h1122_3344, 5'd9, 3'd6, 1, 32'h1122_AABB);
    issue(0, 1, 4'hF, 32'h0000_0100, 32'h80AA_BBCC, 32'h0, 5'd10, 3'd0, 0, 32'h0);
    issue(1, 1, 4'h0, 32'h0000_0103, 32'h0, 32'h0, 5'd11, 3'd1, 1, 32'hFFFF_FF80);
    issue(0, 0, 4'hF, 32'h0000_0200, 32'hDEAD_BEEF, 32'h0, 5'd12, 3'd0, 0, 32'h0);
    drain();
    stall_req = 3;
    issue(0, 1, 4'h0, 32'hA5A5_0001, 32'h0, 32'h0, 5'd7, 3'd0, 1, 32'hA5A5_0001);
    issue(0, 1, 4'h0, 32'h5A5A_0002, 32'h0, 32'h0, 5'd9, 3'd0, 1, 32'h5A5A_0002);
    drain();

    // random traffic
    wb_rand = 1; addr_dly = -1; data_lat = -1;
    for (int i = 0; i < 300; i++) begin
      k  = $urandom_range(0, 9);
      lt = 3'($urandom_range(0, 6));
      a  = 32'h100 + 32'($urandom_range(0, 63));
      if (k < 3) begin
        issue(0, 1'($urandom), 4'h0, $urandom, $urandom, $urandom, 5'($urandom), lt, 0, 32'h0);
      end else if (k < 8) begin
        if (lt == 3'd0) a[1:0] = 2'b00;
        if (lt == 3'd3 || lt == 3'd4) a[0] = 1'b0;
        issue(1, 1, 4'h0, a, $urandom, $urandom, 5'($urandom), lt, 0, 32'h0);
      end else begin
        issue(0, 1'($urandom), wens[$urandom_range(0, 6)], a, $urandom, $urandom,
              5'($urandom), lt, 0, 32'h0);
      end
      repeat ($urandom_range(0, 1)) @(posedge clk);
    end
    drain();

    // reset while a load waits for its data
    auto_mem = 0;
    @(negedge clk);
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    @(negedge clk);
    exe_valid = 1; exe_mem_read = 1; exe_reg_en = 1; exe_mem_wen = 4'h0;
    alu_result = 32'h300; exe_reg_waddr = 5'd3; exe_load_type = 3'd0;
    #4 chk("rst_test_accept", mem_allowin, 1'b1);
    @(posedge clk);
    #1 exe_valid = 0;
    @(negedge clk);
    chk("rst_test_req", {data_req, data_addr}, {1'b1, 32'h300});
    data_addr_ok = 1'b1;
    @(negedge clk);
    data_addr_ok = 1'b0;
    #3 resetn = 1'b0;
    #1;
    chk("mid_rst_mem_valid", mem_valid, 1'b0);
    chk("mid_rst_data_req", data_req, 1'b0);
    chk("mid_rst_allowin", mem_allowin, 1'b1);
    chk("mid_rst_reg", {mem_reg_en, mem_reg_waddr, mem_reg_wdata}, 38'd0);
`ifdef MEMORY_HILO_EN
    chk("mid_rst_hilo", {hi, lo}, 64'd0);
`endif
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    data_data_ok = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("late_data_ok_ignored", {mem_valid, data_req, mem_allowin}, 3'b001);
    end
`ifdef MEMORY_HILO_EN
    exe_MD_complete = 1; exe_MD_result = 64'h1_0000_0002;
    @(negedge clk);
    exe_MD_complete = 0; exe_MD_result = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    chk("hi", hi, 32'd1);
    chk("lo", lo, 32'd2);
`endif
    auto_mem = 1;
    issue(0, 1, 4'h0, 32'h0BAD_F00D, 32'h0, 32'h0, 5'd4, 3'd0, 1, 32'h0BAD_F00D);
    issue(1, 1, 4'h0, 32'h0000_0104, 32'h0, 32'h0, 5'd6, 3'd0, 0, 32'h0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
